// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI read/write arbiters: state encoding, field widths and
// default bus widths.
package axi_lite_pkg;

  localparam int unsigned LEN_W      = 4;
  localparam int unsigned ID_W       = 4;
  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StAddr = ST_ADDR,
    StData = ST_DATA
  } arb_state_e;

  // Pointer width that stays at least one bit wide for degenerate sizes.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: grants the first requester at or after ptr, searching
// upward with wrap-around. Shared by the read and write arbiters.
module rr_pick
  import axi_lite_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned PtrW = ptr_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic            valid
);

  logic [PtrW:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = {1'b0, ptr} + (PtrW + 1)'(i);
      if (idx >= (PtrW + 1)'(N)) begin
        idx = idx - (PtrW + 1)'(N);
      end
      if (!valid && req[idx[PtrW-1:0]]) begin
        gnt[idx[PtrW-1:0]] = 1'b1;
        valid              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read slave between NUM_M masters, one burst at a time.
// Define AXI_RD_ARB_STATS_EN to add per-master saturating burst counters (grant_cnt, stats_clr).
module axi_rd_arbiter
  import axi_lite_pkg::*;
#(
  parameter int unsigned NUM_M  = 2,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef AXI_RD_ARB_STATS_EN
  input  logic                    stats_clr,
  output logic [NUM_M*8-1:0]      grant_cnt,
`endif
  input  logic [NUM_M-1:0]        m_arvalid,
  input  logic [NUM_M*ADDR_W-1:0] m_araddr,
  input  logic [NUM_M*LEN_W-1:0]  m_arlen,
  input  logic [NUM_M*ID_W-1:0]   m_arid,
  output logic [NUM_M-1:0]        m_arready,
  output logic [NUM_M-1:0]        m_rvalid,
  input  logic [NUM_M-1:0]        m_rready,
  output logic [DATA_W-1:0]       m_rdata,
  output logic                    m_rresp,
  output logic                    m_rlast,
  output logic                    s_arvalid,
  output logic [ADDR_W-1:0]       s_araddr,
  output logic [LEN_W-1:0]        s_arlen,
  output logic [ID_W-1:0]         s_arid,
  input  logic                    s_arready,
  input  logic                    s_rvalid,
  input  logic [DATA_W-1:0]       s_rdata,
  input  logic                    s_rresp,
  input  logic                    s_rlast,
  output logic                    s_rready,
  output logic [NUM_M-1:0]        grant,
  output logic                    err_len
);

  localparam int unsigned PtrW = ptr_width(NUM_M);

  arb_state_e       state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [4:0]       beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_len_q, err_len_d;

  logic [NUM_M-1:0] pick_gnt;
  logic             pick_valid;
  logic [PtrW-1:0]  g_idx;
  logic             gnt_arvalid, gnt_rready;
  logic             ar_hs, r_hs, len_bad, burst_done;

  rr_pick #(
    .N(NUM_M)
  ) u_rr_pick (
    .req  (m_arvalid),
    .ptr  (rr_ptr_q),
    .gnt  (pick_gnt),
    .valid(pick_valid)
  );

  // Decode the one-hot grant into an index and mux the granted master's request fields.
  always_comb begin
    g_idx       = '0;
    s_araddr    = '0;
    s_arlen     = '0;
    s_arid      = '0;
    gnt_arvalid = 1'b0;
    gnt_rready  = 1'b0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (grant_q[i]) begin
        g_idx       = PtrW'(i);
        s_araddr    = m_araddr[i*ADDR_W +: ADDR_W];
        s_arlen     = m_arlen[i*LEN_W +: LEN_W];
        s_arid      = m_arid[i*ID_W +: ID_W];
        gnt_arvalid = m_arvalid[i];
        gnt_rready  = m_rready[i];
      end
    end
  end

  always_comb begin
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    case (state_q)
      StAddr: begin
        s_arvalid = gnt_arvalid;
        m_arready = grant_q & {NUM_M{s_arready}};
      end
      StData: begin
        s_rready = gnt_rready;
        m_rvalid = grant_q & {NUM_M{s_rvalid}};
      end
      default: ;
    endcase
  end

  assign m_rdata    = s_rdata;
  assign m_rresp    = s_rresp;
  assign m_rlast    = s_rlast;
  assign grant      = grant_q;
  assign err_len    = err_len_q;
  assign ar_hs      = s_arvalid & s_arready;
  assign r_hs       = s_rvalid & s_rready;
  assign burst_done = (state_q == StData) & r_hs & s_rlast;
  // beat_cnt_q is the 0-based index of the beat being accepted.
  assign len_bad    = s_rlast ? (beat_cnt_q != {1'b0, len_q}) : (beat_cnt_q == {1'b0, len_q});

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    err_len_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_gnt;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (ar_hs) begin
          len_d      = s_arlen;
          beat_cnt_d = '0;
          state_d    = StData;
        end
      end
      StData: begin
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q + 5'd1;
          err_len_d  = len_bad;
          if (s_rlast) begin
            state_d  = StIdle;
            grant_d  = '0;
            rr_ptr_d = (g_idx == PtrW'(NUM_M - 1)) ? '0 : g_idx + PtrW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      err_len_q  <= err_len_d;
    end
  end

`ifdef AXI_RD_ARB_STATS_EN
  logic [NUM_M-1:0][7:0] cnt_q, cnt_d;

  // Clear wins over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (stats_clr) begin
        cnt_d[i] = '0;
      end else if (burst_done && grant_q[i] && (cnt_q[i] != 8'hFF)) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter with a request scoreboard and an in-bench slave model.
// Define AXI_RD_ARB_STATS_EN to also exercise the burst counters.
module tb_axi_rd_arbiter;

  localparam int unsigned NUM_M  = 2;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_M-1:0]        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [NUM_M*ADDR_W-1:0] m_araddr;
  logic [NUM_M*4-1:0]      m_arlen, m_arid;
  logic [DATA_W-1:0]       m_rdata;
  logic                    m_rresp, m_rlast;
  logic                    s_arvalid, s_arready;
  logic [ADDR_W-1:0]       s_araddr;
  logic [3:0]              s_arlen, s_arid;
  logic                    s_rvalid, s_rresp, s_rlast, s_rready;
  logic [DATA_W-1:0]       s_rdata;
  logic [NUM_M-1:0]        grant;
  logic                    err_len;
`ifdef AXI_RD_ARB_STATS_EN
  logic                    stats_clr;
  logic [NUM_M*8-1:0]      grant_cnt;
  logic                    clr_on_last = 1'b0;
`endif

  typedef struct {
    int         m;
    logic [7:0] addr;
    logic [3:0] len;
    logic [3:0] id;
    logic [7:0] data0;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  axi_rd_arbiter #(
    .NUM_M (NUM_M),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef AXI_RD_ARB_STATS_EN
    .stats_clr(stats_clr),
    .grant_cnt(grant_cnt),
`endif
    .m_arvalid(m_arvalid),
    .m_araddr (m_araddr),
    .m_arlen  (m_arlen),
    .m_arid   (m_arid),
    .m_arready(m_arready),
    .m_rvalid (m_rvalid),
    .m_rready (m_rready),
    .m_rdata  (m_rdata),
    .m_rresp  (m_rresp),
    .m_rlast  (m_rlast),
    .s_arvalid(s_arvalid),
    .s_araddr (s_araddr),
    .s_arlen  (s_arlen),
    .s_arid   (s_arid),
    .s_arready(s_arready),
    .s_rvalid (s_rvalid),
    .s_rdata  (s_rdata),
    .s_rresp  (s_rresp),
    .s_rlast  (s_rlast),
    .s_rready (s_rready),
    .grant    (grant),
    .err_len  (err_len)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic request(input int m, input logic [7:0] addr, input logic [3:0] len,
                         input logic [3:0] id, input logic [7:0] data0);
    exp_t e;
    m_arvalid[m]          = 1'b1;
    m_araddr[m*8 +: 8]    = addr;
    m_arlen[m*4 +: 4]     = len;
    m_arid[m*4 +: 4]      = id;
    e.m     = m;
    e.addr  = addr;
    e.len   = len;
    e.id    = id;
    e.data0 = data0;
    sb.push_back(e);
  endtask

  // Serves the oldest expected burst as the slave: address phase, then nbeats beats with
  // RLAST on beat index rlast_at and an optional master-side stall on beat stall_beat.
  task automatic serve(input int nbeats, input int rlast_at, input int stall_beat,
                       input int stall_cycles);
    exp_t       e;
    int         waited;
    logic [1:0] oh;
    logic       last;
    logic       exp_err;
    waited = 0;
    while (s_arvalid !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    check("ar_wait", s_arvalid, 1'b1);
    if (s_arvalid !== 1'b1 || sb.size() == 0) return;
    e  = sb.pop_front();
    oh = 2'b01 << e.m;
    check("grant", grant, oh);
    check("araddr", s_araddr, e.addr);
    check("arlen", s_arlen, e.len);
    check("arid", s_arid, e.id);
    check("arready_lo", m_arready, 2'b00);
    s_arready = 1'b1;
    #1;
    check("arready", m_arready, oh);
    step();
    s_arready     = 1'b0;
    m_arvalid[e.m] = 1'b0;
    #1;
    check("ar_drop", s_arvalid, 1'b0);
    check("err_idle", err_len, 1'b0);
    for (int k = 0; k < nbeats; k++) begin
      last     = (k == rlast_at);
      s_rvalid = 1'b1;
      s_rdata  = e.data0 + 8'(k);
      s_rlast  = last;
      if (k == stall_beat) begin
        m_rready[e.m] = 1'b0;
        #1;
        repeat (stall_cycles) begin
          check("stall_rready", s_rready, 1'b0);
          check("stall_rvalid", m_rvalid, oh);
          step();
        end
        m_rready[e.m] = 1'b1;
      end
      #1;
      check("rvalid", m_rvalid, oh);
      check("rdata", m_rdata, e.data0 + 8'(k));
      check("rlast", m_rlast, last);
      check("rready", s_rready, 1'b1);
      exp_err = last ? (k != int'(e.len)) : (k == int'(e.len));
`ifdef AXI_RD_ARB_STATS_EN
      if (last) stats_clr = clr_on_last;
`endif
      step();
`ifdef AXI_RD_ARB_STATS_EN
      stats_clr = 1'b0;
`endif
      check("err_len", err_len, exp_err);
      check("grant_beat", grant, last ? 2'b00 : oh);
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    m_arvalid = '0;
    m_araddr  = '0;
    m_arlen   = '0;
    m_arid    = '0;
    m_rready  = '1;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rresp   = 1'b0;
    s_rlast   = 1'b0;
`ifdef AXI_RD_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_s_arvalid", s_arvalid, 1'b0);
    check("rst_m_arready", m_arready, 2'b00);
    check("rst_m_rvalid", m_rvalid, 2'b00);
    check("rst_s_rready", s_rready, 1'b0);
    check("rst_err_len", err_len, 1'b0);
    rst = 1'b0;
    step();

    // Single request from m0, one beat; rr_ptr moves to 1.
    request(0, 8'h10, 4'd0, 4'h1, 8'hA5);
    #1;
    check("ar_latency0", s_arvalid, 1'b0);
    step();
    check("ar_latency1", s_arvalid, 1'b1);
    serve(1, 0, -1, 0);
    step();
    check("idle_grant", grant, 2'b00);
    check("idle_err", err_len, 1'b0);

    // Backpressure from m1 on beat 1 for three cycles; rr_ptr back to 0.
    request(1, 8'h20, 4'd3, 4'h2, 8'h30);
    serve(4, 3, 1, 3);

    // Contention with rr_ptr=0: m0 first, then m1.
    request(0, 8'h40, 4'd3, 4'h3, 8'h50);
    request(1, 8'h44, 4'd1, 4'h4, 8'h60);
    serve(4, 3, -1, 0);
    serve(2, 1, -1, 0);

    // Early RLAST: len 2 but RLAST on the second beat.
    request(0, 8'h48, 4'd2, 4'h5, 8'h70);
    serve(2, 1, -1, 0);

    // Contention with rr_ptr=1: m1 first, then m0.
    request(1, 8'h4C, 4'd0, 4'h6, 8'h80);
    request(0, 8'h50, 4'd1, 4'h7, 8'h90);
    serve(1, 0, -1, 0);
    serve(2, 1, -1, 0);

    // Missing RLAST on the third beat: error, stay in DATA until the real RLAST.
    request(0, 8'h54, 4'd2, 4'h8, 8'hA0);
    serve(4, 3, -1, 0);

    // Reset during beat 1 of a 4-beat m0 burst (rr_ptr is 1 here).
    m_arvalid[0]   = 1'b1;
    m_araddr[7:0]  = 8'h60;
    m_arlen[3:0]   = 4'd3;
    step();
    check("pre_rst_grant", grant, 2'b01);
    s_arready = 1'b1;
    step();
    s_arready    = 1'b0;
    m_arvalid[0] = 1'b0;
    s_rvalid     = 1'b1;
    s_rdata      = 8'hC0;
    step();
    s_rdata = 8'hC1;
    #1;
    check("pre_rst_rvalid", m_rvalid, 2'b01);
    rst = 1'b1;
    #1;
    check("mid_rst_grant", grant, 2'b00);
    check("mid_rst_m_rvalid", m_rvalid, 2'b00);
    check("mid_rst_s_rready", s_rready, 1'b0);
    check("mid_rst_s_arvalid", s_arvalid, 1'b0);
    check("mid_rst_m_arready", m_arready, 2'b00);
    s_rvalid = 1'b0;
    step();
    rst = 1'b0;
    step();

    // rr_ptr must be 0 again: m0 wins over m1.
    request(0, 8'h64, 4'd0, 4'h9, 8'hD0);
    request(1, 8'h68, 4'd0, 4'hA, 8'hE0);
    serve(1, 0, -1, 0);
    serve(1, 0, -1, 0);

`ifdef AXI_RD_ARB_STATS_EN
    check("cnt_m0_pre", grant_cnt[7:0], 8'd1);
    check("cnt_m1_pre", grant_cnt[15:8], 8'd1);
    for (int b = 0; b < 300; b++) begin
      request(0, 8'(b), 4'd0, 4'(b), 8'(b));
      serve(1, 0, -1, 0);
    end
    check("cnt_m0_sat", grant_cnt[7:0], 8'hFF);
    check("cnt_m1_hold", grant_cnt[15:8], 8'd1);
    clr_on_last = 1'b1;
    request(0, 8'h77, 4'd0, 4'h3, 8'h11);
    serve(1, 0, -1, 0);
    clr_on_last = 1'b0;
    check("cnt_m0_clr", grant_cnt[7:0], 8'd0);
    check("cnt_m1_clr", grant_cnt[15:8], 8'd0);
`endif

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
